// File: rtl/aes128_encrypt_core.sv
// aes128_encrypt_core
//   Iterative AES-128 encryption engine (FIPS-197). One cipher round per
//   clock; round keys are expanded on the fly from the previous round key,
//   so only the current 128-bit round key is stored.
//
// Handshake (both sides): a transfer happens at a rising clk edge where the
//   producer's valid and the consumer's ready are both 1. valid, once raised
//   by this core, stays up with stable data until the transfer edge; ready
//   never depends combinationally on valid.
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   synchronous reset, active HIGH despite the name
//   in_valid   in   key / inputData presented
//   in_ready   out  core idle and able to accept a block
//   key        in   128-bit cipher key, byte 0 = bits [127:120]
//   inputData  in   128-bit plaintext, column-major byte order
//   out_valid  out  outputData holds a finished ciphertext
//   out_ready  in   downstream accepts the ciphertext
//   outputData out  128-bit ciphertext (held until next result or reset)
//   round      out  current round index, 1..10 while running, else 0 (debug)
//
// FSM visibility: IDLE <=> in_ready, DONE <=> out_valid, RUN <=> round != 0.
module aes128_encrypt_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] inputData,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] outputData,
  output logic [3:0]   round
);

  if (NR != 10) begin : g_nr_check
    $error("aes128_encrypt_core: only NR = 10 is supported");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       fsm_state;
  logic [127:0] state_reg;
  logic [127:0] key_reg;

  // ---------------- GF(2^8) helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as a^254 (0 maps to 0 naturally),
  // followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, inv;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    inv  = gf_mul(gf_mul(a240, a12), a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // ---------------- round datapath ----------------
  logic [127:0] sub_shift;   // SubBytes + ShiftRows
  logic [127:0] mixed;       // MixColumns(sub_shift)
  logic [127:0] rk;          // next round key
  logic [127:0] round_out;
  logic [7:0]   a0, a1, a2, a3;
  logic [7:0]   rcon;
  logic [31:0]  w0, w1, w2, w3, sub_rot, n0, n1, n2, n3;

  // Byte index = 4*col + row; row r of the output takes column (c+r)%4.
  always_comb begin
    sub_shift = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_shift[127-8*(4*c+r) -: 8] = sbox(state_reg[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
  end

  always_comb begin
    mixed = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sub_shift[127-32*c -: 8];
      a1 = sub_shift[119-32*c -: 8];
      a2 = sub_shift[111-32*c -: 8];
      a3 = sub_shift[103-32*c -: 8];
      mixed[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mixed[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mixed[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mixed[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  always_comb begin
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];
  // SubWord(RotWord(w3))
  assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign n0 = w0 ^ sub_rot ^ {rcon, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk = {n0, n1, n2, n3};

  // Final round skips MixColumns.
  assign round_out = ((round == LAST_ROUND) ? sub_shift : mixed) ^ rk;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (n_rst) begin
      fsm_state  <= IDLE;
      round      <= 4'd0;
      state_reg  <= '0;
      key_reg    <= '0;
      outputData <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (fsm_state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= inputData ^ key;
            key_reg   <= key;
            round     <= 4'd1;
            in_ready  <= 1'b0;
            fsm_state <= RUN;
          end
        end
        RUN: begin
          state_reg <= round_out;
          key_reg   <= rk;
          if (round == LAST_ROUND) begin
            outputData <= round_out;
            out_valid  <= 1'b1;
            round      <= 4'd0;
            fsm_state  <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm_state <= IDLE;
          end
        end
        default: begin
          fsm_state <= IDLE;
          round     <= 4'd0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
